// File: rtl/ch_stream_serializer_if.sv
// Stream bundle for ch_stream_serializer: a wide valid/ready input and a narrow valid/ready/last output.
// The master modport is the side that drives words in and accepts beats; slave is the serializer.
interface ch_stream_serializer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4
);
  logic                 io_in_valid;
  logic [IN_WIDTH-1:0]  io_in_data;
  logic                 io_in_ready;
  logic                 io_out_valid;
  logic [OUT_WIDTH-1:0] io_out_data;
  logic                 io_out_ready;
  logic                 io_out_last;
  logic                 io_busy;

  modport master (
    output io_in_valid, io_in_data, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy
  );

  modport slave (
    input  io_in_valid, io_in_data, io_out_ready,
    output io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy
  );
endinterface

// File: rtl/ch_stream_serializer.sv
// Wide-to-narrow stream serializer: one IN_WIDTH word becomes IN_WIDTH/OUT_WIDTH beats, LSB slice first.
// Define CH_SERIALIZER_PARITY_EN to append an XOR-of-slices parity beat after each word.
module ch_stream_serializer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ch_stream_serializer_if.slave  io
);
  // IN_WIDTH must be a multiple of OUT_WIDTH, giving RATIO >= 2.
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO + 1);
`ifdef CH_SERIALIZER_PARITY_EN
  localparam int LAST_BEAT = RATIO;
`else
  localparam int LAST_BEAT = RATIO - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_BEAT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]          state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IN_WIDTH-1:0] shreg_reg, shreg_next;

  logic in_fire;
  logic out_fire;
  logic out_last;
  logic sending;

  assign sending  = (state_reg == ST_SEND);
  assign out_last = sending && (idx_reg == LAST_IDX);
  assign out_fire = sending && io.io_out_ready;
  assign in_fire  = io.io_in_valid && io.io_in_ready;

  // io_in_ready depends combinationally on io_out_ready so a new word can load on the final beat.
  assign io.io_in_ready  = !reset && (!sending || (out_last && io.io_out_ready));
  assign io.io_out_valid = sending;
  assign io.io_out_last  = out_last;
  assign io.io_busy      = sending;

`ifdef CH_SERIALIZER_PARITY_EN
  logic [OUT_WIDTH-1:0] parity_reg, parity_next;
  logic [OUT_WIDTH-1:0] parity_calc;
  logic [OUT_WIDTH-1:0] in_slice [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign in_slice[gi] = io.io_in_data[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  always_comb begin
    parity_calc = '0;
    for (int i = 0; i < RATIO; i++) begin
      parity_calc = parity_calc ^ in_slice[i];
    end
  end

  assign io.io_out_data = !sending ? '0 :
                          (idx_reg == LAST_IDX) ? parity_reg : shreg_reg[OUT_WIDTH-1:0];
`else
  assign io.io_out_data = sending ? shreg_reg[OUT_WIDTH-1:0] : '0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
`ifdef CH_SERIALIZER_PARITY_EN
    parity_next = parity_reg;
`endif
    if (in_fire) begin
      // Covers both the IDLE accept and the back-to-back reload on the final beat.
      state_next = ST_SEND;
      idx_next   = '0;
      shreg_next = io.io_in_data;
`ifdef CH_SERIALIZER_PARITY_EN
      parity_next = parity_calc;
`endif
    end else if (out_fire) begin
      if (out_last) begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end else begin
        shreg_next = shreg_reg >> OUT_WIDTH;
        idx_next   = idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      shreg_reg <= '0;
`ifdef CH_SERIALIZER_PARITY_EN
      parity_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
`ifdef CH_SERIALIZER_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end
endmodule

// File: tb/tb_ch_stream_serializer.sv
// Scoreboard bench for ch_stream_serializer: words push expected beats, a monitor pops on every out transfer.
// Honours CH_SERIALIZER_PARITY_EN by expecting the extra parity beat.
module tb_ch_stream_serializer;
  logic clk = 1'b0;
  logic reset;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

`ifdef CH_SERIALIZER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic [4:0] exp_q [$];
  int         fire_cyc [$];

  ch_stream_serializer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) bus ();

  ch_stream_serializer #(.IN_WIDTH(16), .OUT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected beats: 4-bit slices LSB first, plus parity when enabled.
  task automatic push_word(input logic [15:0] w);
    logic [3:0] p;
    logic       l;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      l = (i == 3) && (NB == 4);
      exp_q.push_back({l, w[i*4 +: 4]});
      p = p ^ w[i*4 +: 4];
    end
`ifdef CH_SERIALIZER_PARITY_EN
    exp_q.push_back({1'b1, p});
`endif
  endtask

  // Offer a word; returns the cycle in which it was accepted. Leaves io_in_valid high.
  task automatic offer(input logic [15:0] w, output int acc_cyc);
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = w;
    acc_cyc = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.io_in_ready === 1'b1) begin
        acc_cyc = cycle;
        push_word(w);
        $display("accept word=%h cyc=%0d", w, cycle);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: word %h not accepted within 64 cycles", w);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (k == 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    @(negedge clk);
    check("idle_out_valid", bus.io_out_valid, 0);
    check("idle_in_ready", bus.io_in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] e;
    int a, a2, n0;

    reset = 1'b1;
    bus.io_in_valid  = 1'b0;
    bus.io_in_data   = '0;
    bus.io_out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (reset === 1'b0 && bus.io_out_valid === 1'b1 && bus.io_out_ready === 1'b1) begin
          fire_cyc.push_back(cycle);
          $display("beat cyc=%0d data=%h last=%b", cycle, bus.io_out_data, bus.io_out_last);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data %h last %b, expected none", bus.io_out_data, bus.io_out_last);
          end else begin
            e = exp_q.pop_front();
            check("beat", {27'd0, bus.io_out_last, bus.io_out_data}, {27'd0, e});
          end
          check("busy_on_beat", bus.io_busy, 1);
          if (bus.io_out_last === 1'b1) check("in_ready_on_last", bus.io_in_ready, 1);
        end
      end
    join_none

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", bus.io_out_valid, 0);
    check("rst_out_data", bus.io_out_data, 0);
    check("rst_out_last", bus.io_out_last, 0);
    check("rst_busy", bus.io_busy, 0);
    check("rst_in_ready_forced", bus.io_in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.io_in_ready, 1);
    @(posedge clk); #1;

    // Single word, continuous ready: 3,C,5,A on consecutive cycles after accept
    n0 = fire_cyc.size();
    offer(16'hA5C3, a);
    bus.io_in_valid = 1'b0;
    drain();
    check("first_beat_latency", fire_cyc[n0], a + 1);
    check("word_beats_consecutive", fire_cyc[n0+NB-1], a + NB);

    // Backpressure during beat 2
    offer(16'hA5C3, a);
    bus.io_in_valid = 1'b0;
    @(posedge clk); #1;
    bus.io_out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_valid", bus.io_out_valid, 1);
      check("stall_data", bus.io_out_data, 4'hC);
      check("stall_last", bus.io_out_last, 0);
      @(posedge clk); #1;
    end
    bus.io_out_ready = 1'b1;
    drain();

    // Back-to-back words, no bubble
    n0 = fire_cyc.size();
    offer(16'h1234, a);
    offer(16'h5678, a2);
    bus.io_in_valid = 1'b0;
    drain();
    check("b2b_accept_on_last", a2, a + NB);
    check("b2b_no_bubble", fire_cyc[n0+2*NB-1] - fire_cyc[n0], 2*NB - 1);

    // Reset mid-word after two beats
    offer(16'hFFFF, a);
    bus.io_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_forced", bus.io_in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.io_out_valid, 0);
    check("midrst_in_ready", bus.io_in_ready, 1);
    @(posedge clk); #1;
    offer(16'h0001, a);
    bus.io_in_valid = 1'b0;
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
